dac_output_formatter: RTL and testbench

Parametrised DAC output stage that converts the wide signed DUC/TX datapath sample into the DAC code word. It sits between the final interpolation stage and the DAC pins. It adds runtime gain (bit-drop) selection, round-half-up, DC offset trim, saturation with clip reporting, mute, and selectable offset-binary or two's-complement output. It is a 3-stage pipeline with a valid qualifier.

---
 rtl/dac_output_formatter.sv | 160 ++++++++++++++++
 tb/tb_dac_output_formatter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/dac_output_formatter.sv
// dac_output_formatter: 3-stage DAC code formatter.
// Stages: round/drop, offset/saturate, mute/format + clip flag and counter.
//
// Ports
//   clk_in, reset         : clock, synchronous active-high reset
//   data_valid_in         : DATA_IN/drop carry a new sample
//   DATA_IN [IN_WIDTH]    : signed input sample
//   drop [DROP_WIDTH]     : LSBs to discard (clamped to IN_WIDTH-OUT_WIDTH)
//   dc_offset [OUT_WIDTH] : signed trim, used in stage 2
//   mute, fmt             : used in stage 3 (fmt 0 = offset binary)
//   clip_clr              : clears clip_count
//   data_valid_out        : DATA_OUT updated this cycle
//   DATA_OUT [OUT_WIDTH]  : DAC code word
//   clip                  : clip hold flag
//   clip_count [CNT_WIDTH]: saturating clipped-sample count
module dac_output_formatter #(
  parameter int IN_WIDTH   = 27,
  parameter int OUT_WIDTH  = 14,
  parameter int DROP_WIDTH = 5,
  parameter int CLIP_HOLD  = 4800000,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  data_valid_in,
  input  logic [IN_WIDTH-1:0]   DATA_IN,
  input  logic [DROP_WIDTH-1:0] drop,
  input  logic [OUT_WIDTH-1:0]  dc_offset,
  input  logic                  mute,
  input  logic                  fmt,
  input  logic                  clip_clr,
  output logic                  data_valid_out,
  output logic [OUT_WIDTH-1:0]  DATA_OUT,
  output logic                  clip,
  output logic [CNT_WIDTH-1:0]  clip_count
);

  localparam int SW = IN_WIDTH + 1;
  localparam int TW = IN_WIDTH + 2;
  localparam int HW = $clog2(CLIP_HOLD) + 1;

  localparam logic [DROP_WIDTH-1:0] DMAX =
    DROP_WIDTH'(IN_WIDTH - OUT_WIDTH);
  localparam logic signed [TW-1:0] YMAX =
    TW'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  // ~max == -max-1 in two's complement
  localparam logic signed [TW-1:0] YMIN = ~YMAX;
  localparam logic [OUT_WIDTH-1:0] MID =
    {1'b1, {(OUT_WIDTH-1){1'b0}}};

  // stage 1: clamp drop, add half-LSB, arithmetic shift
  logic [DROP_WIDTH-1:0] d;
  logic signed [SW-1:0]  half;
  logic signed [SW-1:0]  sum;
  logic signed [SW-1:0]  s1;
  logic                  v1;

  always_comb begin
    d    = (drop > DMAX) ? DMAX : drop;
    half = '0;
    if (d != '0)
      half = SW'(1) << (d - 1'b1);
    sum = $signed({DATA_IN[IN_WIDTH-1], DATA_IN}) + half;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      v1 <= 1'b0;
      s1 <= '0;
    end else begin
      v1 <= data_valid_in;
      if (data_valid_in)
        s1 <= sum >>> d;
    end
  end

  // stage 2: offset and saturate
  logic signed [TW-1:0]  t;
  logic [OUT_WIDTH-1:0]  y;
  logic                  sat;
  logic [OUT_WIDTH-1:0]  y2;
  logic                  clip2;
  logic                  v2;

  always_comb begin
    t = $signed({s1[SW-1], s1}) +
        $signed({{(TW-OUT_WIDTH){dc_offset[OUT_WIDTH-1]}},
                 dc_offset});
    y   = t[OUT_WIDTH-1:0];
    sat = 1'b0;
    if (t > YMAX) begin
      y   = YMAX[OUT_WIDTH-1:0];
      sat = 1'b1;
    end else if (t < YMIN) begin
      y   = YMIN[OUT_WIDTH-1:0];
      sat = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      v2    <= 1'b0;
      y2    <= '0;
      clip2 <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) begin
        y2    <= y;
        clip2 <= sat;
      end
    end
  end

  // stage 3: mute, output format, clip tracking
  logic [OUT_WIDTH-1:0] yv;
  logic [OUT_WIDTH-1:0] code;
  logic                 evt;
  logic [HW-1:0]        hold;

  always_comb begin
    yv   = mute ? '0 : y2;
    code = fmt ? yv : {~yv[OUT_WIDTH-1], yv[OUT_WIDTH-2:0]};
    evt  = v2 & clip2;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      data_valid_out <= 1'b0;
      DATA_OUT       <= fmt ? '0 : MID;
    end else begin
      data_valid_out <= v2;
      if (v2)
        DATA_OUT <= code;
    end
  end

  // flag covers the event cycle plus CLIP_HOLD-1 countdown cycles
  always_ff @(posedge clk_in) begin
    if (reset) begin
      hold <= '0;
      clip <= 1'b0;
    end else begin
      clip <= evt | (hold != '0);
      if (evt)
        hold <= HW'(CLIP_HOLD - 1);
      else if (hold != '0)
        hold <= hold - 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset)
      clip_count <= '0;
    else if (clip_clr)
      clip_count <= evt ? CNT_WIDTH'(1) : '0;
    else if (evt && clip_count != '1)
      clip_count <= clip_count + 1'b1;
  end

endmodule

// File: tb/tb_dac_output_formatter.sv
// tb_dac_output_formatter: directed vectors for dac_output_formatter.
// Runs with CLIP_HOLD 8 and CNT_WIDTH 4.
module tb_dac_output_formatter;

  logic        clk_in = 1'b0;
  logic        reset = 1'b1;
  logic        data_valid_in = 1'b0;
  logic [26:0] DATA_IN = '0;
  logic [4:0]  drop = '0;
  logic [13:0] dc_offset = '0;
  logic        mute = 1'b0;
  logic        fmt = 1'b0;
  logic        clip_clr = 1'b0;
  logic        data_valid_out;
  logic [13:0] DATA_OUT;
  logic        clip;
  logic [3:0]  clip_count;

  int checks = 0;
  int errors = 0;

  dac_output_formatter #(
    .IN_WIDTH(27), .OUT_WIDTH(14), .DROP_WIDTH(5),
    .CLIP_HOLD(8), .CNT_WIDTH(4)
  ) dut (
    .clk_in(clk_in), .reset(reset),
    .data_valid_in(data_valid_in), .DATA_IN(DATA_IN),
    .drop(drop), .dc_offset(dc_offset),
    .mute(mute), .fmt(fmt), .clip_clr(clip_clr),
    .data_valid_out(data_valid_out), .DATA_OUT(DATA_OUT),
    .clip(clip), .clip_count(clip_count)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_one(input int v, input int drp,
                         input int off, input logic mt,
                         input logic f, input logic [13:0] exp,
                         input string tag);
    int lat;
    DATA_IN       = 27'(v);
    drop          = 5'(drp);
    dc_offset     = 14'(off);
    mute          = mt;
    fmt           = f;
    data_valid_in = 1'b1;
    tick();
    data_valid_in = 1'b0;
    lat = 1;
    while (!data_valid_out && lat < 8) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd3);
    chk(tag, 32'(DATA_OUT), 32'(exp));
  endtask

  // one full-scale clip at cycle 0, optional second at `second`
  task automatic clip_run(input int second, output int hi);
    hi = 0;
    DATA_IN   = 27'((1 << 26) - 1);
    drop      = 5'd13;
    dc_offset = '0;
    for (int i = 0; i < 30; i++) begin
      data_valid_in = (i == 0) || (second != 0 && i == second);
      tick();
      if (clip) hi++;
    end
    data_valid_in = 1'b0;
  endtask

  int hi;
  int n;
  int k;
  int din [3];
  logic [13:0] ev [3];

  initial begin
    din = '{5 * 8192, 9 * 8192, -3 * 8192};
    ev  = '{14'h2005, 14'h2009, 14'h1FFD};

    idle(3);
    reset = 1'b0;
    tick();
    chk("rst_dvo", 32'(data_valid_out), 32'd0);
    chk("rst_out", 32'(DATA_OUT), 32'h2000);
    chk("rst_clip", 32'(clip), 32'd0);
    chk("rst_cnt", 32'(clip_count), 32'd0);

    run_one(4095, 13, 0, 1'b0, 1'b0, 14'h2000, "rnd_4095");
    run_one(4096, 13, 0, 1'b0, 1'b0, 14'h2001, "rnd_4096");
    run_one(-4097, 13, 0, 1'b0, 1'b0, 14'h1FFF, "rnd_m4097");
    run_one(-4096, 13, 0, 1'b0, 1'b0, 14'h2000, "rnd_half");
    run_one(8192, 31, 0, 1'b0, 1'b0, 14'h2001, "drop_clamp");

    run_one((1 << 26) - 1, 13, 0, 1'b0, 1'b0, 14'h3FFF, "sat_pos");
    chk("sat_pos_clip", 32'(clip), 32'd1);
    chk("sat_pos_cnt", 32'(clip_count), 32'd1);
    run_one(-(1 << 26), 13, 0, 1'b0, 1'b0, 14'h0000, "sat_neg");
    chk("sat_neg_cnt", 32'(clip_count), 32'd1);
    run_one(0, 0, 0, 1'b0, 1'b0, 14'h2000, "zero");

    run_one(0, 0, 100, 1'b0, 1'b0, 14'h2064, "off_ob");
    run_one(0, 0, 100, 1'b0, 1'b1, 14'h0064, "off_tc");
    run_one(0, 0, -1, 1'b0, 1'b1, 14'h3FFF, "off_m1");
    run_one(8191 * 8192, 13, 1, 1'b0, 1'b0, 14'h3FFF, "off_sat");
    chk("off_sat_cnt", 32'(clip_count), 32'd2);

    idle(12);
    chk("pre_mute_clip", 32'(clip), 32'd0);
    mute = 1'b1;
    fmt  = 1'b0;
    clip_run(0, hi);
    chk("mute_hold", 32'(hi), 32'd8);
    chk("mute_out", 32'(DATA_OUT), 32'h2000);
    chk("mute_cnt", 32'(clip_count), 32'd3);
    chk("mute_clip_end", 32'(clip), 32'd0);

    mute = 1'b0;
    clip_run(5, hi);
    chk("ext_hold", 32'(hi), 32'd13);
    chk("ext_cnt", 32'(clip_count), 32'd5);

    DATA_IN = 27'((1 << 26) - 1);
    drop    = 5'd13;
    data_valid_in = 1'b1;
    idle(20);
    data_valid_in = 1'b0;
    idle(4);
    chk("cnt_sat", 32'(clip_count), 32'd15);

    for (int i = 0; i < 6; i++) begin
      data_valid_in = (i == 0);
      clip_clr      = (i == 2);
      tick();
    end
    clip_clr = 1'b0;
    chk("clr_evt", 32'(clip_count), 32'd1);
    clip_clr = 1'b1;
    tick();
    clip_clr = 1'b0;
    chk("clr_only", 32'(clip_count), 32'd0);

    chk("pre_rst_out", 32'(DATA_OUT), 32'h3FFF);
    DATA_IN = 27'd4096;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      data_valid_in = (i < 2);
      reset         = (i == 2);
      tick();
      if (data_valid_out) n++;
    end
    data_valid_in = 1'b0;
    chk("flush_dvo", 32'(n), 32'd0);
    chk("flush_out", 32'(DATA_OUT), 32'h2000);

    k = 0;
    for (int i = 0; i < 15; i++) begin
      data_valid_in = (i == 0) || (i == 3) || (i == 4);
      DATA_IN = 27'(din[(i == 0) ? 0 : (i == 3) ? 1 : 2]);
      tick();
      if (data_valid_out && k < 3) begin
        chk("gap_out", 32'(DATA_OUT), 32'(ev[k]));
        k++;
      end else if (k > 0) begin
        chk("gap_hold", 32'(DATA_OUT), 32'(ev[k-1]));
      end
    end
    data_valid_in = 1'b0;
    chk("gap_count", 32'(k), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
